// File: rtl/date_set_ctrl.sv
// Key-driven date editor: shadows year/month/day in BCD, commits with a one-cycle dateSetMod strobe.
// Optional build macro EDIT_TIMEOUT_EN adds an auto-abort after TIMEOUT_BLINKS idle blink half-periods.
module date_set_ctrl #(
    parameter int BLINK_HALF     = 25000000,
    parameter int TIMEOUT_BLINKS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_next,
    input  logic       key_up,
    input  logic       key_down,
    input  logic [3:0] year3,
    input  logic [3:0] year2,
    input  logic [3:0] year1,
    input  logic [3:0] year0,
    input  logic [3:0] month1,
    input  logic [3:0] month0,
    input  logic [3:0] day1,
    input  logic [3:0] day0,
    output logic [3:0] year_set3,
    output logic [3:0] year_set2,
    output logic [3:0] year_set1,
    output logic [3:0] year_set0,
    output logic [3:0] month_set1,
    output logic [3:0] month_set0,
    output logic [3:0] day_set1,
    output logic [3:0] day_set0,
    output logic       dateSetMod,
    output logic       editing,
    output logic [1:0] edit_field,
    output logic       blink
);

    if (BLINK_HALF < 1 || TIMEOUT_BLINKS < 1) begin : g_param_check
        $error("date_set_ctrl: BLINK_HALF and TIMEOUT_BLINKS must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, EDIT_YEAR, EDIT_MONTH, EDIT_DAY, COMMIT} state_t;

    localparam logic [1:0] FIELD_NONE  = 2'd0;
    localparam logic [1:0] FIELD_YEAR  = 2'd1;
    localparam logic [1:0] FIELD_MONTH = 2'd2;
    localparam logic [1:0] FIELD_DAY   = 2'd3;

    localparam int            BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    state_t        state;
    logic [15:0]   year_sh;
    logic [7:0]    month_sh;
    logic [7:0]    day_sh;
    logic [BW-1:0] blink_cnt;
    logic [31:0]   stepped;
    logic          any_key;

`ifdef EDIT_TIMEOUT_EN
    localparam int            TW        = (TIMEOUT_BLINKS > 1) ? $clog2(TIMEOUT_BLINKS) : 1;
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_BLINKS - 1);
    logic [TW-1:0] tout_cnt;
`endif

    // Leap test straight on BCD: 10*t+u is divisible by 4 iff u is even and u[1] equals t[0].
    function automatic logic is_leap(input logic [15:0] y);
        if (y[7:0] != 8'h00) return (y[0] == 1'b0) && (y[1] == y[4]);
        else                 return (y[8] == 1'b0) && (y[9] == y[12]);
    endfunction

    function automatic logic [7:0] max_day(input logic [7:0] m, input logic leap);
        case (m)
            8'h02:                      return leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] clamp_day(input logic [7:0] d, input logic [7:0] mx);
        return (d > mx) ? mx : d;
    endfunction

    function automatic logic [15:0] year_inc(input logic [15:0] y);
        logic [15:0] r;
        logic        carry;
        r     = y;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] year_dec(input logic [15:0] y);
        logic [15:0] r;
        logic        borrow;
        r      = y;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] month_inc(input logic [7:0] m);
        if (m == 8'h12)           return 8'h01;
        else if (m[3:0] == 4'd9)  return 8'h10;
        else                      return {m[7:4], m[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] month_dec(input logic [7:0] m);
        if (m == 8'h01)           return 8'h12;
        else if (m == 8'h10)      return 8'h09;
        else                      return {m[7:4], m[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] day_inc(input logic [7:0] d, input logic [7:0] mx);
        if (d >= mx)              return 8'h01;
        else if (d[3:0] == 4'd9)  return {d[7:4] + 4'd1, 4'd0};
        else                      return {d[7:4], d[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] day_dec(input logic [7:0] d, input logic [7:0] mx);
        if (d <= 8'h01)           return mx;
        else if (d[3:0] == 4'd0)  return {d[7:4] - 4'd1, 4'd9};
        else                      return {d[7:4], d[3:0] - 4'd1};
    endfunction

    // Year/month changes re-clamp the day against the new month length in the same update.
    function automatic logic [31:0] edit_date(input state_t st, input logic up,
                                              input logic [15:0] y, input logic [7:0] m,
                                              input logic [7:0] d);
        logic [15:0] ny;
        logic [7:0]  nm;
        logic [7:0]  nd;
        ny = y;
        nm = m;
        nd = d;
        case (st)
            EDIT_YEAR: begin
                ny = up ? year_inc(y) : year_dec(y);
                nd = clamp_day(d, max_day(m, is_leap(ny)));
            end
            EDIT_MONTH: begin
                nm = up ? month_inc(m) : month_dec(m);
                nd = clamp_day(d, max_day(nm, is_leap(y)));
            end
            EDIT_DAY: begin
                nd = up ? day_inc(d, max_day(m, is_leap(y))) : day_dec(d, max_day(m, is_leap(y)));
            end
            default: ;
        endcase
        return {ny, nm, nd};
    endfunction

    always_comb begin
        stepped = edit_date(state, key_up, year_sh, month_sh, day_sh);
        any_key = key_mode | key_next | key_up | key_down;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            year_sh    <= 16'h2019;
            month_sh   <= 8'h01;
            day_sh     <= 8'h01;
            dateSetMod <= 1'b0;
            editing    <= 1'b0;
            edit_field <= FIELD_NONE;
            blink      <= 1'b0;
            blink_cnt  <= '0;
`ifdef EDIT_TIMEOUT_EN
            tout_cnt   <= '0;
`endif
        end else begin
            dateSetMod <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_mode) begin
                        year_sh    <= {year3, year2, year1, year0};
                        month_sh   <= {month1, month0};
                        day_sh     <= {day1, day0};
                        state      <= EDIT_YEAR;
                        editing    <= 1'b1;
                        edit_field <= FIELD_YEAR;
                        blink      <= 1'b0;
                        blink_cnt  <= '0;
`ifdef EDIT_TIMEOUT_EN
                        tout_cnt   <= '0;
`endif
                    end
                end
                EDIT_YEAR, EDIT_MONTH, EDIT_DAY: begin
                    if (any_key) begin
                        blink     <= 1'b0;
                        blink_cnt <= '0;
`ifdef EDIT_TIMEOUT_EN
                        tout_cnt  <= '0;
`endif
                    end else if (blink_cnt == BLINK_LAST) begin
                        blink_cnt <= '0;
                        blink     <= ~blink;
`ifdef EDIT_TIMEOUT_EN
                        // The final half-period ends the session silently; the shadow keeps its edits.
                        if (tout_cnt == TOUT_LAST) begin
                            state      <= IDLE;
                            editing    <= 1'b0;
                            edit_field <= FIELD_NONE;
                            blink      <= 1'b0;
                            tout_cnt   <= '0;
                        end else begin
                            tout_cnt <= tout_cnt + TW'(1);
                        end
`endif
                    end else begin
                        blink_cnt <= blink_cnt + BW'(1);
                    end

                    if (key_mode) begin
                        state      <= COMMIT;
                        dateSetMod <= 1'b1;
                        editing    <= 1'b0;
                        edit_field <= FIELD_NONE;
                    end else if (key_next) begin
                        if (state == EDIT_YEAR) begin
                            state      <= EDIT_MONTH;
                            edit_field <= FIELD_MONTH;
                        end else if (state == EDIT_MONTH) begin
                            state      <= EDIT_DAY;
                            edit_field <= FIELD_DAY;
                        end else begin
                            state      <= EDIT_YEAR;
                            edit_field <= FIELD_YEAR;
                        end
                    end else if (key_up || key_down) begin
                        {year_sh, month_sh, day_sh} <= stepped;
                    end
                end
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign {year_set3, year_set2, year_set1, year_set0} = year_sh;
    assign {month_set1, month_set0}                     = month_sh;
    assign {day_set1, day_set0}                         = day_sh;

endmodule
